round_dealer: RTL and testbench
===============================

// Module: round_dealer
// PURPOSE
//  Game-round controller on the driving side of the hand-card comparator.
//  Draws pseudo-random cards (1..MAX_CARD) for player 1 and player 2 and presents them on p1_handcard/p2_handcard.
//  Samples the comparator's 2-bit matchresult, keeps both scores, and ends the game when a player reaches WIN_SCORE.
// PARAMETERS
//  WIN_SCORE  5        rounds needed to win a game (1..2**SCORE_W-1)
//  SCORE_W    3        score counter width
//  MAX_CARD   13       highest legal card value; 0 and >MAX_CARD are never dealt
//  SEED       4'b0001  LFSR reset value (must be nonzero)
//  SETTLE     1        cycles cards are held valid before matchresult is sampled (>=1)
// PORTS
//  clk           in   1        single clock, all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  start         in   1        pulse: begin new game (clears scores)
//  next          in   1        pulse: deal next round
//  matchresult   in   2        comparator result: 01 tie, 11 p2 higher, 10 p1 higher, 00 illegal
//  p1_handcard   out  4        card dealt to player 1
//  p2_handcard   out  4        card dealt to player 2
//  cards_valid   out  1        cards stable and presented to comparator
//  round_result  out  2        last judged round, same encoding as matchresult (00 = none yet)
//  p1_score      out  SCORE_W  player 1 rounds won
//  p2_score      out  SCORE_W  player 2 rounds won
//  game_over     out  1        high in DONE
//  winner        out  2        00 none, 01 p1, 10 p2; valid when game_over
//  proto_err     out  1        sticky: illegal matchresult (00) sampled; cleared by rst/start
// BEHAVIOUR
//  - rst: state=IDLE, LFSR=SEED, all outputs 0.
//  - LFSR: 4-bit Fibonacci, q <= {q[2:0], q[3]^q[2]}, period 15; advances every non-reset cycle in every state.
//  - FSM states: IDLE, DRAW1, DRAW2, SHOW, JUDGE, WAIT, DONE.
//  - IDLE: on start -> DRAW1; scores, round_result, winner, proto_err cleared.
//  - DRAW1: if 1<=q<=MAX_CARD, latch p1_handcard=q -> DRAW2; else stay (skip). DRAW2 same for p2 -> SHOW.
//  - cards_valid=0 in DRAW1/DRAW2; old cards may remain on the bus but are not valid.
//  - SHOW: cards_valid=1 for SETTLE cycles -> JUDGE. JUDGE keeps cards_valid=1.
//  - JUDGE (1 cycle): sample matchresult.
//      10: p1_score+1. 11: p2_score+1. 01: no change.
//      00: set proto_err, score as tie, round_result=01.
//    round_result registered. If the updated score == WIN_SCORE -> DONE, else -> WAIT.
//  - WAIT: cards_valid=1, cards held. next -> DRAW1. start -> clear scores/round_result/proto_err, DRAW1.
//  - DONE: game_over=1, winner set, cards held, cards_valid=0; next ignored. start -> clear, DRAW1.
//  - start and next in the same cycle: start wins.
//  - start outside IDLE/WAIT/DONE: ignored. next outside WAIT: ignored.
//  - rst in any state, including mid-draw: immediate return to reset values; no partial score update.
//  - Latency: start in cycle 0 (no skips) -> p1 latched in cycle 1, p2 in cycle 2, cards_valid from cycle 3,
//    JUDGE in cycle 3+SETTLE, scores visible the following cycle.
//  - Scores never wrap: the game ends at WIN_SCORE.
// STRUCTURE
//  - Shared package game_pkg: state enum; MR_TIE=2'b01, MR_P2=2'b11, MR_P1=2'b10, MR_BAD=2'b00;
//    WIN_NONE/WIN_P1/WIN_P2; CARD_W=4.
//  - One sub-module card_lfsr (clk, rst, SEED -> q[3:0]).
//  - FSM, card latches and score counters live in round_dealer.
// TESTING  (comparator model in bench drives matchresult from the presented cards)
//  1. SEED=0001, start in first cycle after rst -> p1=2, p2=4, cards_valid from cycle 3;
//     JUDGE sees 11 -> p2_score=1, round_result=11, WAIT.
//  2. SEED=0111, start -> LFSR 1111,1110 skipped; p1=12, p2=8; 10 -> p1_score=1.
//  3. WIN_SCORE=2, force matchresult=10 each round, pulse next twice ->
//     game_over=1, winner=01, p1_score=2; extra next ignored.
//  4. matchresult forced 00 in JUDGE -> proto_err=1, scores unchanged, round_result=01;
//     proto_err stays set until start.
//  5. start and next same cycle in WAIT with p1_score=1 -> scores cleared, new deal begins.
//  6. rst asserted in DRAW2 -> next cycle: IDLE, all outputs 0, LFSR=SEED.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and encodings for the round dealer
package game_pkg;

  localparam int CARD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW1,
    S_DRAW2,
    S_SHOW,
    S_JUDGE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] MR_TIE = 2'b01;
  localparam logic [1:0] MR_P2  = 2'b11;
  localparam logic [1:0] MR_P1  = 2'b10;
  localparam logic [1:0] MR_BAD = 2'b00;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // A raw LFSR value is only dealt when it is a real card face.
  function automatic logic card_ok(input logic [CARD_W-1:0] v, input int max_card);
    return (v != '0) && (int'(v) <= max_card);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - 4-bit Fibonacci LFSR card source, period 15
module card_lfsr
  import game_pkg::*;
#(
  parameter logic [CARD_W-1:0] SEED = 4'b0001
) (
  input  logic              clk,
  input  logic              rst,
  output logic [CARD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {q[2:0], q[3] ^ q[2]};
  end

endmodule

// File: rtl/round_dealer.sv
// rtl/round_dealer.sv - deals cards, judges comparator results, keeps score
module round_dealer
  import game_pkg::*;
#(
  parameter int              WIN_SCORE = 5,
  parameter int              SCORE_W   = 3,
  parameter int              MAX_CARD  = 13,
  parameter logic [CARD_W-1:0] SEED    = 4'b0001,
  parameter int              SETTLE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               next,
  input  logic [1:0]         matchresult,
  output logic [CARD_W-1:0]  p1_handcard,
  output logic [CARD_W-1:0]  p2_handcard,
  output logic               cards_valid,
  output logic [1:0]         round_result,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               proto_err
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [CARD_W-1:0]  lfsr_q;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;
  logic [1:0]         rr_next;
  logic               bad_mr;
  logic               begin_game;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // An illegal comparator answer is scored as a tie and flagged.
  always_comb begin
    p1_next = p1_score;
    p2_next = p2_score;
    rr_next = matchresult;
    bad_mr  = 1'b0;
    case (matchresult)
      MR_P1:   p1_next = p1_score + SCORE_W'(1);
      MR_P2:   p2_next = p2_score + SCORE_W'(1);
      MR_TIE:  ;
      default: begin
        bad_mr  = 1'b1;
        rr_next = MR_TIE;
      end
    endcase
  end

  assign begin_game = start && (state == S_IDLE || state == S_WAIT || state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      settle_cnt   <= '0;
      p1_handcard  <= '0;
      p2_handcard  <= '0;
      cards_valid  <= 1'b0;
      round_result <= 2'b00;
      p1_score     <= '0;
      p2_score     <= '0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
      proto_err    <= 1'b0;
    end else if (begin_game) begin
      state        <= S_DRAW1;
      cards_valid  <= 1'b0;
      round_result <= 2'b00;
      p1_score     <= '0;
      p2_score     <= '0;
      game_over    <= 1'b0;
      winner       <= WIN_NONE;
      proto_err    <= 1'b0;
    end else begin
      case (state)
        S_DRAW1: begin
          if (card_ok(lfsr_q, MAX_CARD)) begin
            p1_handcard <= lfsr_q;
            state       <= S_DRAW2;
          end
        end
        S_DRAW2: begin
          if (card_ok(lfsr_q, MAX_CARD)) begin
            p2_handcard <= lfsr_q;
            cards_valid <= 1'b1;
            settle_cnt  <= '0;
            state       <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (settle_cnt == SET_W'(SETTLE - 1)) state <= S_JUDGE;
          else settle_cnt <= settle_cnt + SET_W'(1);
        end
        S_JUDGE: begin
          p1_score     <= p1_next;
          p2_score     <= p2_next;
          round_result <= rr_next;
          if (bad_mr) proto_err <= 1'b1;
          if (p1_next == WIN_S || p2_next == WIN_S) begin
            state       <= S_DONE;
            game_over   <= 1'b1;
            cards_valid <= 1'b0;
            winner      <= (p1_next == WIN_S) ? WIN_P1 : WIN_P2;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (next) begin
            state       <= S_DRAW1;
            cards_valid <= 1'b0;
          end
        end
        S_IDLE, S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_dealer.sv
// tb/tb_round_dealer.sv - scoreboard bench for round_dealer
module tb_round_dealer;
  import game_pkg::*;

  localparam int WIN_SCORE = 5;
  localparam int SCORE_W   = 3;
  localparam int MAX_CARD  = 13;
  localparam int SETTLE    = 1;
  localparam logic [3:0] SEED = 4'b0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic next = 1'b0;
  logic [1:0] matchresult;
  logic [3:0] p1_handcard, p2_handcard;
  logic cards_valid, game_over, proto_err;
  logic [1:0] round_result, winner;
  logic [SCORE_W-1:0] p1_score, p2_score;

  always #5 clk = ~clk;

  round_dealer #(
    .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W), .MAX_CARD(MAX_CARD),
    .SEED(SEED), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .next(next), .matchresult(matchresult),
    .p1_handcard(p1_handcard), .p2_handcard(p2_handcard), .cards_valid(cards_valid),
    .round_result(round_result), .p1_score(p1_score), .p2_score(p2_score),
    .game_over(game_over), .winner(winner), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seq[15];
  int mode = 0;
  int rounds_issued = 0;
  int rounds_done = 0;

  typedef struct {
    int rise; int p1; int p2; int rr; int s1; int s2; int over; int win; int perr;
  } exp_t;
  exp_t sbq[$];

  int m_s1, m_s2, m_over, m_win, m_perr;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Comparator model: forced answers or the honest comparison of the shown cards.
  always_comb begin
    if (mode == 1)      matchresult = 2'b10;
    else if (mode == 2) matchresult = 2'b00;
    else if (p1_handcard > p2_handcard) matchresult = 2'b10;
    else if (p2_handcard > p1_handcard) matchresult = 2'b11;
    else matchresult = 2'b01;
  end

  function automatic int lfsr_at(input int c);
    return seq[c % 15];
  endfunction

  function automatic int next_legal(input int c);
    int j = c;
    while (!(lfsr_at(j) >= 1 && lfsr_at(j) <= MAX_CARD)) j++;
    return j;
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0; m_perr = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_p1card"}, int'(p1_handcard), 0);
    check({tag, "_p2card"}, int'(p2_handcard), 0);
    check({tag, "_valid"}, int'(cards_valid), 0);
    check({tag, "_rr"}, int'(round_result), 0);
    check({tag, "_s1"}, int'(p1_score), 0);
    check({tag, "_s2"}, int'(p2_score), 0);
    check({tag, "_over"}, int'(game_over), 0);
    check({tag, "_win"}, int'(winner), 0);
    check({tag, "_perr"}, int'(proto_err), 0);
  endtask

  // Command a round; the expected outcome is derived from the card sequence and model scores.
  task automatic issue(input bit s, input bit n, input int md, input bit release_rst);
    exp_t e;
    int j1, j2, rr;
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    if (s) model_clear();
    j1 = next_legal(cyc + 1);
    j2 = next_legal(j1 + 1);
    e.rise = j2 + 1;
    e.p1 = lfsr_at(j1);
    e.p2 = lfsr_at(j2);
    if (md == 1)      rr = 2;
    else if (md == 2) rr = 0;
    else if (e.p1 > e.p2) rr = 2;
    else if (e.p2 > e.p1) rr = 3;
    else rr = 1;
    if (rr == 0) begin m_perr = 1; rr = 1; end
    if (rr == 2) m_s1++;
    if (rr == 3) m_s2++;
    if (m_s1 == WIN_SCORE) begin m_over = 1; m_win = 1; end
    else if (m_s2 == WIN_SCORE) begin m_over = 1; m_win = 2; end
    e.rr = rr; e.s1 = m_s1; e.s2 = m_s2; e.over = m_over; e.win = m_win; e.perr = m_perr;
    sbq.push_back(e);
    rounds_issued++;
    mode = md;
    start = s;
    next = n;
    @(negedge clk);
    start = 1'b0;
    next = 1'b0;
  endtask

  task automatic wait_round(input string tag);
    int t = 0;
    while (rounds_done != rounds_issued && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (rounds_done != rounds_issued) begin
      check({tag, "_timeout"}, rounds_done, rounds_issued);
      rounds_done = rounds_issued;
      sbq.delete();
    end
  endtask

  initial begin : monitor
    bit prev_cv = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cards_valid && !prev_cv) begin
        if (sbq.size() == 0) begin
          check("unexpected_deal", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("rise_cycle", cyc, e.rise);
          check("p1_card", int'(p1_handcard), e.p1);
          check("p2_card", int'(p2_handcard), e.p2);
          repeat (SETTLE + 1) @(negedge clk);
          check("round_result", int'(round_result), e.rr);
          check("p1_score", int'(p1_score), e.s1);
          check("p2_score", int'(p2_score), e.s2);
          check("game_over", int'(game_over), e.over);
          check("winner", int'(winner), e.win);
          check("proto_err", int'(proto_err), e.perr);
          check("valid_after", int'(cards_valid), (e.over != 0) ? 0 : 1);
          rounds_done++;
        end
      end
      prev_cv = cards_valid;
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stim
    int k, j1, r, md, guard;
    seq[0] = int'(SEED);
    for (int i = 1; i < 15; i++)
      seq[i] = ((seq[i-1] * 2) % 16) + (((seq[i-1] / 8) + (seq[i-1] / 4)) % 2);
    model_clear();

    repeat (3) @(negedge clk);
    check_zero("reset");

    // First deal straight out of reset: 2 vs 4, player 2 scores.
    issue(1'b1, 1'b0, 0, 1'b1);
    wait_round("t1");
    check("t1_p1", int'(p1_handcard), 2);
    check("t1_p2", int'(p2_handcard), 4);
    check("t1_s2", int'(p2_score), 1);
    check("t1_rr", int'(round_result), 3);

    for (int i = 0; i < 16; i++) begin
      r  = $urandom_range(0, 9);
      md = ($urandom_range(0, 9) == 0) ? 2 : 0;
      if (m_over != 0)  issue(1'b1, 1'b0, md, 1'b0);
      else if (r == 0)  issue(1'b1, 1'b1, md, 1'b0);
      else if (r == 1)  issue(1'b1, 1'b0, md, 1'b0);
      else              issue(1'b0, 1'b1, md, 1'b0);
      wait_round("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Player 1 wins every round until the game ends; further next pulses are ignored.
    issue(1'b1, 1'b0, 1, 1'b0);
    wait_round("win");
    guard = 0;
    while (m_over == 0 && guard < 10) begin
      issue(1'b0, 1'b1, 1, 1'b0);
      wait_round("win");
      guard++;
    end
    check("win_over", int'(game_over), 1);
    check("win_winner", int'(winner), 1);
    check("win_s1", int'(p1_score), WIN_SCORE);
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
    repeat (6) @(negedge clk);
    check("done_over", int'(game_over), 1);
    check("done_valid", int'(cards_valid), 0);
    check("done_s1", int'(p1_score), WIN_SCORE);

    // Illegal comparator answer: tie scored, proto_err sticky until start.
    issue(1'b1, 1'b0, 2, 1'b0);
    wait_round("bad");
    check("bad_perr", int'(proto_err), 1);
    check("bad_rr", int'(round_result), 1);
    check("bad_s1", int'(p1_score), 0);
    issue(1'b0, 1'b1, 0, 1'b0);
    wait_round("bad2");
    check("bad_sticky", int'(proto_err), 1);
    issue(1'b1, 1'b0, 1, 1'b0);
    wait_round("clr");
    check("clr_perr", int'(proto_err), 0);
    check("clr_s1", int'(p1_score), 1);

    // start together with next in WAIT: start wins, scores cleared.
    issue(1'b1, 1'b1, 0, 1'b0);
    check("both_s1", int'(p1_score), 0);
    check("both_valid", int'(cards_valid), 0);
    wait_round("both");

    // Reset in the middle of a deal.
    @(negedge clk);
    k = cyc;
    next = 1'b1;
    j1 = next_legal(k + 1);
    @(negedge clk);
    next = 1'b0;
    while (cyc < j1 + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    model_clear();
    sbq.delete();
    issue(1'b1, 1'b0, 0, 1'b1);
    wait_round("after_rst");
    check("rst_p1", int'(p1_handcard), 2);
    check("rst_p2", int'(p2_handcard), 4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
